// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set bit of req starting at ptr.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand_idx;

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_idx = ptr + ID_W'(i);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold-time preemption and registered grant outputs.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic [N_REQ-1:0] others;
    logic             at_max;
    logic             release_now;
    logic [N_REQ-1:0] pick_req;
    logic [ID_W-1:0]  pick_ptr;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;

    // One picker serves both the idle arbitration and the handover on release.
    assign pick_req = (state_q == GRANT) ? others : req;
    assign pick_ptr = (state_q == GRANT) ? (gnt_id_q + ID_W'(1)) : ptr_q;

    rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        others      = req & ~id2onehot(gnt_id_q);
        at_max      = (cnt_q == CNT_W'(MAX_HOLD));
        release_now = done | ~req[gnt_id_q] | (at_max & (|others));

        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    cnt_d       = CNT_W'(1);
                    gnt_d       = id2onehot(pick_idx);
                    gnt_id_d    = pick_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = pick_ptr;
                    if (pick_found) begin
                        cnt_d    = CNT_W'(1);
                        gnt_d    = id2onehot(pick_idx);
                        gnt_id_d = pick_idx;
                    end else begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        gnt_d       = '0;
                        gnt_id_d    = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (!at_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arbiter_4;

    localparam int unsigned MAX_HOLD = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Behavioural model: owner index (-1 = none), pointer and hold count as plain integers.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int o;
        int p;
        int h;
        int others;
        bit rel;
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_hold  <= 0;
        end else begin
            o = m_owner;
            p = m_ptr;
            h = m_hold;
            if (o < 0) begin
                for (int k = 0; k < 4; k++)
                    if (o < 0 && req[(p + k) % 4]) begin
                        o = (p + k) % 4;
                        h = 1;
                    end
            end else begin
                others = int'(req) & ~(1 << o);
                rel = done || !req[o] || (h == int'(MAX_HOLD) && others != 0);
                if (rel) begin
                    p = (o + 1) % 4;
                    o = -1;
                    h = 0;
                    for (int k = 0; k < 4; k++)
                        if (o < 0 && ((others >> ((p + k) % 4)) & 1) == 1) begin
                            o = (p + k) % 4;
                            h = 1;
                        end
                end else if (h < int'(MAX_HOLD)) begin
                    h = h + 1;
                end
            end
            m_owner <= o;
            m_ptr   <= p;
            m_hold  <= h;
        end
    end

    function automatic logic [3:0] exp_gnt(input int owner);
        return (owner < 0) ? 4'b0000 : 4'(1 << owner);
    endfunction

    function automatic logic [1:0] exp_id(input int owner);
        return (owner < 0) ? 2'd0 : 2'(owner);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of the registered outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt", 32'(gnt), 32'(exp_gnt(m_owner)));
            check("gnt_id", 32'(gnt_id), 32'(exp_id(m_owner)));
            check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("onehot0", 32'($onehot0(gnt)), 32'd1);
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_id", 32'(gnt_id), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_ptr", 32'(dut.ptr_q), 32'h0);
        check("rst_cnt", 32'(dut.cnt_q), 32'h0);

        // First grant from reset.
        rst_n = 1'b1;
        req   = 4'b1010;
        @(negedge clk);
        check("d027_gnt", 32'(gnt), 32'h2);
        check("d027_id", 32'(gnt_id), 32'h1);
        check("d027_valid", 32'(gnt_valid), 32'h1);
        check("d027_model", 32'(exp_gnt(m_owner)), 32'h2);

        // done hands over to requester 3 without an idle cycle.
        req  = 4'b1011;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("d028_gnt", 32'(gnt), 32'h8);
        check("d028_id", 32'(gnt_id), 32'h3);
        check("d028_valid", 32'(gnt_valid), 32'h1);
        check("d028_ptr", 32'(dut.ptr_q), 32'h2);
        check("d028_mptr", 32'(m_ptr), 32'h2);

        // Owner drops its request with nobody waiting.
        req = 4'b0000;
        @(negedge clk);
        check("d031_gnt", 32'(gnt), 32'h0);
        check("d031_valid", 32'(gnt_valid), 32'h0);
        check("d031_ptr", 32'(dut.ptr_q), 32'h0);

        // Preemption after exactly MAX_HOLD cycles.
        req = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("d029_hold", 32'(gnt), 32'h1);
        end
        @(negedge clk);
        check("d029_preempt", 32'(gnt), 32'h4);
        check("d029_model", 32'(exp_gnt(m_owner)), 32'h4);

        // Lone requester keeps the grant; counter saturates.
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("d030_gnt", 32'(gnt), 32'h4);
        end
        check("d030_cnt", 32'(dut.cnt_q), 32'h8);
        check("d030_mhold", 32'(m_hold), 32'h8);

        // done while idle is ignored.
        req = 4'b0000;
        @(negedge clk);
        done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("d018_idle", 32'(gnt_valid), 32'h0);
        end
        done = 1'b0;

        // Asynchronous reset in the middle of a grant.
        req = 4'b1111;
        @(negedge clk);
        check("d032_pre", 32'(gnt_valid), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("d032_gnt", 32'(gnt), 32'h0);
        check("d032_id", 32'(gnt_id), 32'h0);
        check("d032_valid", 32'(gnt_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("d032_after", 32'(gnt), 32'h1);

        // Randomized traffic; requests change occasionally so hold limits get exercised.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        req  = 4'b0000;
        done = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before preemption when other requests are pending (legal range 1..15).
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  4  request lines, bit i from requester i, level-sensitive.
REQ-005 done  input  1  current owner releases the resource; sampled only while gnt_valid=1.
REQ-006 gnt  output  4  one-hot grant; all-zero when no grant.
REQ-007 gnt_id  output  2  binary index of the granted requester; 0 when gnt_valid=0.
REQ-008 gnt_valid  output  1  a grant is active.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner held).
REQ-010 All outputs SHALL be registered; no combinational path from req or done to any output.
REQ-011 A rotating pointer ptr (2 bits) SHALL hold the highest-priority index; priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 In IDLE with req != 0 at a clock edge: grant the first set bit in priority order; gnt, gnt_id and gnt_valid SHALL update at that edge, giving one-cycle latency from req sampled to grant visible.
REQ-013 In IDLE with req == 0: remain in IDLE, outputs 0.
REQ-014 In GRANT, a release SHALL occur at the edge where any of these holds: done=1; req[owner]=0; hold count equals MAX_HOLD and at least one other req bit is set.
REQ-015 On release: ptr SHALL become owner+1 (mod 4); the candidate set is req with the owner bit masked; if non-empty, grant its first bit in the new priority order at the same edge (no idle bubble), else go to IDLE with outputs 0.
REQ-016 Hold counter (4 bits) SHALL load 1 at each new grant, increment each GRANT cycle without release, and saturate at MAX_HOLD.
REQ-017 At MAX_HOLD with no other requester, the owner SHALL keep the grant indefinitely; the counter stays at MAX_HOLD.
REQ-018 done asserted while gnt_valid=0 SHALL be ignored.
REQ-019 gnt SHALL always be one-hot or zero, and gnt[gnt_id]=1 whenever gnt_valid=1.
REQ-020 A request dropping for a non-owner SHALL have no effect on the current grant.

Reset
REQ-021 On rst_n=0, asynchronously: state=IDLE, ptr=0, hold count=0, gnt=0000, gnt_id=00, gnt_valid=0.
REQ-022 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-023 The first edge after rst_n deasserts SHALL be evaluated as IDLE with ptr=0, so req[0] has highest priority.

Structure
REQ-024 Shared package rr_arb_pkg SHALL hold N_REQ=4, ID_W=2, CNT_W=4 and the state encoding (IDLE=0, GRANT=1).
REQ-025 Sub-module rr_pick4, purely combinational, SHALL take the 4-bit request vector and ptr and return a found flag plus the 2-bit index; the FSM, counter and pointer live in rr_arbiter_4.
REQ-026 Target size is 120-400 lines of RTL in total.

Verification
REQ-027 Reset, then req=1010 -> after one edge gnt=0010, gnt_id=1, gnt_valid=1.
REQ-028 Owner 1 holding, req=1011, pulse done -> at the next edge gnt=1000, gnt_id=3, ptr=2, with no idle cycle between grants.
REQ-029 req=0101 held with done never asserted, MAX_HOLD=8 -> owner 0 is preempted after exactly 8 grant cycles and gnt=0100 on the following cycle.
REQ-030 Only req[2] set for 20 cycles -> gnt=0100 continuously, and the counter saturates at 8.
REQ-031 Owner 3, then req[3] drops with req=0000 -> next edge IDLE, all outputs 0, ptr=0.
REQ-032 rst_n pulled low mid-cycle during a grant -> gnt, gnt_id and gnt_valid go to 0 before the next clock edge; after release req=1111 -> gnt=0001.
